// File: rtl/sonar_pkg.sv
// Shared types and default timing constants for the sonar ping scheduler.
package sonar_pkg;

  localparam int unsigned DEF_BURST_CYCLES  = 524288;
  localparam int unsigned DEF_LISTEN_CYCLES = 16252927;
  localparam int unsigned DEF_GAP_CYCLES    = 0;
  localparam int unsigned DEF_ANGLE_WIDTH   = 8;
  localparam int          DEF_ANGLE_MIN     = -30;
  localparam int          DEF_ANGLE_MAX     = 30;
  localparam int          DEF_ANGLE_STEP    = 10;
  localparam int unsigned DEF_RANGE_WIDTH   = 16;

  typedef logic signed [DEF_ANGLE_WIDTH-1:0] angle_t;

  typedef enum logic [2:0] {IDLE, BURST, LISTEN, REPORT, GAP} sched_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/angle_stepper.sv
// Beam steering angle register; steps once per advance_in strobe.
// SWEEP_BIDIR_EN selects a ping-pong sweep instead of the sawtooth wrap.
module angle_stepper
  import sonar_pkg::*;
#(
  parameter int unsigned ANGLE_WIDTH = DEF_ANGLE_WIDTH,
  parameter int          ANGLE_MIN   = DEF_ANGLE_MIN,
  parameter int          ANGLE_MAX   = DEF_ANGLE_MAX,
  parameter int          ANGLE_STEP  = DEF_ANGLE_STEP
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          advance_in,
  output logic signed [ANGLE_WIDTH-1:0] angle_out,
  output logic                          at_end_c
);

  localparam int unsigned SW = ANGLE_WIDTH + 1;

  // One extra bit keeps the end-of-sweep compare free of overflow.
  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] up_sum;

  assign ext    = SW'(angle_out);
  assign up_sum = ext + SW'(ANGLE_STEP);

`ifdef SWEEP_BIDIR_EN
  logic signed [SW-1:0] dn_sum;
  logic                 descending;

  assign dn_sum   = ext - SW'(ANGLE_STEP);
  assign at_end_c = descending ? (dn_sum < SW'(ANGLE_MIN)) : (up_sum > SW'(ANGLE_MAX));

  // Endpoints are reported once: on a flip, step away in the new direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle_out  <= ANGLE_WIDTH'(ANGLE_MIN);
      descending <= 1'b0;
    end else if (advance_in) begin
      if (at_end_c) begin
        descending <= ~descending;
        angle_out  <= descending ? up_sum[ANGLE_WIDTH-1:0] : dn_sum[ANGLE_WIDTH-1:0];
      end else begin
        angle_out  <= descending ? dn_sum[ANGLE_WIDTH-1:0] : up_sum[ANGLE_WIDTH-1:0];
      end
    end
  end
`else
  assign at_end_c = up_sum > SW'(ANGLE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle_out <= ANGLE_WIDTH'(ANGLE_MIN);
    end else if (advance_in) begin
      angle_out <= at_end_c ? ANGLE_WIDTH'(ANGLE_MIN) : up_sum[ANGLE_WIDTH-1:0];
    end
  end
`endif

endmodule

// File: rtl/beam_sweep_scheduler.sv
// Sonar ping sequencer: BURST -> LISTEN -> REPORT -> GAP, first-echo capture, beam stepping.
// Define SWEEP_BIDIR_EN for a ping-pong angle sweep (default: sawtooth).
module beam_sweep_scheduler
  import sonar_pkg::*;
#(
  parameter int unsigned BURST_CYCLES  = DEF_BURST_CYCLES,
  parameter int unsigned LISTEN_CYCLES = DEF_LISTEN_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned ANGLE_WIDTH   = DEF_ANGLE_WIDTH,
  parameter int          ANGLE_MIN     = DEF_ANGLE_MIN,
  parameter int          ANGLE_MAX     = DEF_ANGLE_MAX,
  parameter int          ANGLE_STEP    = DEF_ANGLE_STEP,
  parameter int unsigned RANGE_WIDTH   = DEF_RANGE_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic                          tof_valid_in,
  input  logic [RANGE_WIDTH-1:0]        range_in,
  output logic                          burst_active_out,
  output logic                          burst_start_out,
  output logic                          listen_active_out,
  output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
  output logic                          result_valid_out,
  output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
  output logic [RANGE_WIDTH-1:0]        result_range_out,
  output logic                          result_hit_out,
  output logic                          sweep_done_out
);

  localparam int unsigned MAX_LEN  = max3(BURST_CYCLES, LISTEN_CYCLES, GAP_CYCLES);
  localparam int unsigned CNT_W    = $clog2(MAX_LEN) + 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  sched_state_t           state;
  logic [CNT_W-1:0]       cnt;
  logic [RANGE_WIDTH-1:0] cap_range;
  logic                   hit;
  logic                   phase_last_c;
  logic                   start_c;
  logic                   advance_c;
  logic                   capture_c;
  logic                   at_end_c;

  // Phase-end decode and the conditions that launch a new burst.
  always_comb begin
    phase_last_c = 1'b0;
    case (state)
      BURST:   phase_last_c = (cnt == CNT_W'(BURST_CYCLES - 1));
      LISTEN:  phase_last_c = (cnt == CNT_W'(LISTEN_CYCLES - 1));
      GAP:     phase_last_c = (cnt == CNT_W'(GAP_LAST));
      default: phase_last_c = 1'b0;
    endcase
    start_c   = enable_in && ((state == IDLE) ||
                              (state == REPORT && GAP_CYCLES == 0) ||
                              (state == GAP && phase_last_c));
    advance_c = (state == LISTEN) && phase_last_c;
    capture_c = (state == LISTEN) && tof_valid_in && !hit;
  end

  angle_stepper #(
    .ANGLE_WIDTH(ANGLE_WIDTH),
    .ANGLE_MIN  (ANGLE_MIN),
    .ANGLE_MAX  (ANGLE_MAX),
    .ANGLE_STEP (ANGLE_STEP)
  ) u_stepper (
    .clk       (clk_in),
    .rst       (rst_in),
    .advance_in(advance_c),
    .angle_out (beam_angle_out),
    .at_end_c  (at_end_c)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= IDLE;
      cnt               <= '0;
      cap_range         <= '0;
      hit               <= 1'b0;
      burst_active_out  <= 1'b0;
      burst_start_out   <= 1'b0;
      listen_active_out <= 1'b0;
      result_valid_out  <= 1'b0;
      result_angle_out  <= '0;
      result_range_out  <= '0;
      result_hit_out    <= 1'b0;
      sweep_done_out    <= 1'b0;
    end else begin
      burst_start_out  <= 1'b0;
      result_valid_out <= 1'b0;
      sweep_done_out   <= 1'b0;
      if (start_c) begin
        state            <= BURST;
        cnt              <= '0;
        burst_active_out <= 1'b1;
        burst_start_out  <= 1'b1;
        cap_range        <= '0;
        hit              <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          BURST: begin
            if (phase_last_c) begin
              state             <= LISTEN;
              cnt               <= '0;
              burst_active_out  <= 1'b0;
              listen_active_out <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          LISTEN: begin
            if (capture_c) begin
              cap_range <= range_in;
              hit       <= 1'b1;
            end
            // Report sees a strobe that lands in the final listen cycle.
            if (phase_last_c) begin
              state             <= REPORT;
              cnt               <= '0;
              listen_active_out <= 1'b0;
              result_valid_out  <= 1'b1;
              result_angle_out  <= beam_angle_out;
              result_range_out  <= capture_c ? range_in : cap_range;
              result_hit_out    <= hit | capture_c;
              sweep_done_out    <= at_end_c;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          REPORT: begin
            cnt   <= '0;
            state <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end
          GAP: begin
            if (phase_last_c) state <= IDLE;
            else              cnt   <= cnt + CNT_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/beam_sweep_scheduler.md
Name: beam_sweep_scheduler

Overview:
- Sequences the sonar ping cycle: transmit burst, listen window, result report, gap.
- Steps the steered beam angle across a sweep once per ping, and emits the burst and pipeline-reset strobes for the transmit/receive datapath.
- Captures the first time-of-flight range reported in each listen window and publishes it with the angle it was measured at.
- Sits between the sin LUT / beamformers / time_of_flight chain and the display/readout logic; it replaces the free-running pwm burst timer.

Parameters:
- BURST_CYCLES, 524288, transmit burst length in clk cycles (>=1)
- LISTEN_CYCLES, 16252927, listen window length in clk cycles (>=1)
- GAP_CYCLES, 0, idle cycles after report before next burst (0 = none)
- ANGLE_WIDTH, 8, signed beam angle width
- ANGLE_MIN, -30, first sweep angle, degrees
- ANGLE_MAX, 30, last sweep angle, degrees
- ANGLE_STEP, 10, angle increment (>0)
- RANGE_WIDTH, 16, range word width

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  asynchronous active-high reset
- enable_in  input  1  run pings while high
- tof_valid_in  input  1  range_in valid strobe from time_of_flight
- range_in  input  RANGE_WIDTH  measured range
- burst_active_out  output  1  high during BURST; gates transmitter outputs
- burst_start_out  output  1  1-cycle pulse on first BURST cycle; datapath reset
- listen_active_out  output  1  high during LISTEN; gates ADC SPI triggering
- beam_angle_out  output  ANGLE_WIDTH signed  current steering angle
- result_valid_out  output  1  1-cycle result strobe
- result_angle_out  output  ANGLE_WIDTH signed  angle of reported ping
- result_range_out  output  RANGE_WIDTH  captured range (0 if no hit)
- result_hit_out  output  1  echo seen during the ping
- sweep_done_out  output  1  1-cycle pulse with the last report of a sweep

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release): state IDLE; all strobes, flags and results 0; beam_angle_out = ANGLE_MIN; counters 0.
- FSM states: IDLE, BURST, LISTEN, REPORT, GAP.
- IDLE: if enable_in is sampled high, go to BURST on the next cycle.
- BURST: lasts exactly BURST_CYCLES cycles.
  - burst_active_out high throughout.
  - burst_start_out high only in the first cycle.
  - Clears the capture register and hit flag in that first cycle.
- LISTEN: lasts exactly LISTEN_CYCLES cycles with listen_active_out high.
  - First tof_valid_in captures range_in and sets hit.
  - Later strobes are ignored.
- tof_valid_in is ignored in every state except LISTEN.
- REPORT: exactly 1 cycle.
  - result_valid_out = 1; result_angle_out = beam_angle_out; result_range_out = captured range; result_hit_out = hit.
  - Result outputs hold until the next REPORT.
  - beam_angle_out advances in the same cycle.
- Angle advance: if beam_angle_out + ANGLE_STEP > ANGLE_MAX, wrap to ANGLE_MIN and pulse sweep_done_out with result_valid_out; otherwise add ANGLE_STEP.
  - Compute the sum at ANGLE_WIDTH+1 bits so the compare cannot overflow.
- GAP: lasts GAP_CYCLES cycles; with GAP_CYCLES = 0 it is skipped.
  - On exit, go to BURST if enable_in is high, else IDLE.
- Ping period = BURST_CYCLES + LISTEN_CYCLES + 1 + GAP_CYCLES cycles, with no dead cycle between consecutive pings.
- enable_in dropped mid-ping: the current ping completes through REPORT/GAP, then the FSM goes to IDLE. beam_angle_out is retained; it does not reset.
- A tof_valid_in arriving in the last LISTEN cycle is captured.
- Phase counter: width $clog2(max phase length)+1; it never wraps inside a phase.

Optional Feature:
- Macro: SWEEP_BIDIR_EN.
- Defined: ping-pong sweep ANGLE_MIN→ANGLE_MAX→ANGLE_MIN.
  - Direction flips at each end; end angles are not repeated.
  - sweep_done_out pulses at each endpoint report.
  - Direction resets to ascending.
- Undefined: sawtooth wrap as above; no direction register.

Decomposition:
- Package sonar_pkg holds:
  - typedef enum sched_state_t {IDLE, BURST, LISTEN, REPORT, GAP}
  - typedef angle_t (signed ANGLE_WIDTH)
  - default timing constants
- Sub-module angle_stepper: holds beam_angle_out, direction and the wrap/flip logic, with an advance_in strobe. The scheduler FSM stays in the top of the block.

Test Plan:
- Params BURST=4, LISTEN=10, GAP=2; enable_in high before first edge → burst_start_out at cycle 1, burst_active_out cycles 1–4, listen_active_out cycles 5–14, result_valid_out at 15, next burst_start_out at 18.
- tof_valid_in with range 0x0123 at cycle 7 and 0x0456 at cycle 9 → report at 15: range 0x0123, hit 1, angle -30.
- No tof_valid_in in the window; a strobe in BURST at cycle 2 → range 0, hit 0.
- 7 consecutive pings → angles -30,-20,…,30; sweep_done_out only with the 7th report; 8th ping angle -30. With SWEEP_BIDIR_EN: 8th ping angle 20, and sweep_done_out pulses again at the -30 report.
- enable_in dropped at cycle 6 → ping finishes, report at 15, GAP 16–17, IDLE at 18; re-enable → next ping at angle -20.
- rst_in asserted mid-LISTEN, asynchronous to clk → outputs 0 immediately, beam_angle_out -30, IDLE after release.
